chacha_param_server: RTL

Register-file server that sits directly upstream of the ChaCha20 ASIC top-level and answers its key/nonce/counter chunk requests. The host programs 8 key words, 3 nonce words and 1 counter word over a simple write port. The block returns the requested 32-bit chunk on the top-level's chunk stream inputs. It optionally auto-increments the block counter after every completed block, so consecutive blocks use counter, counter+1, and so on.

---
 rtl/chacha_param_server.sv | 132 +++++++++++++
 1 files changed

// File: rtl/chacha_param_server.sv
// Key/nonce/counter register file that serves 32-bit chunks to the ChaCha20 top-level.
// Responses are registered at the request-accept edge; the block counter can auto-increment on core_done.
module chacha_param_server (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic        auto_inc,
    input  logic        core_busy,
    input  logic        core_done,
    input  logic        chunk_request,
    input  logic [1:0]  request_type,
    input  logic [4:0]  chunk_index,
    output logic        chunk_valid,
    output logic [1:0]  chunk_type,
    output logic [31:0] chunk,
    output logic        wr_reject,
    output logic        req_err,
    output logic        ctr_wrap
);

    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

    typedef struct packed {
        logic        valid;
        logic [1:0]  typ;
        logic [31:0] data;
    } resp_t;

    logic [7:0][31:0] key;
    logic [2:0][31:0] nonce;
    logic [31:0]      ctr;

    state_t      state, state_nxt;
    logic        accept;
    logic        legal;
    logic [31:0] word;
    resp_t       resp;
    logic        req_err_q, wr_reject_q, ctr_wrap_q;

    logic wr_ok, wr_ctr, inc;
    assign wr_ok  = cfg_we && !core_busy && (cfg_addr <= 4'd11);
    assign wr_ctr = wr_ok && (cfg_addr == 4'd11);
    assign inc    = core_done && auto_inc;

    // Host write has priority over the auto-increment on the counter word.
    always_ff @(posedge clk) begin
        if (rst) begin
            key         <= '0;
            nonce       <= '0;
            ctr         <= '0;
            wr_reject_q <= 1'b0;
            ctr_wrap_q  <= 1'b0;
        end else begin
            if (wr_ok && !cfg_addr[3])
                key[cfg_addr[2:0]] <= cfg_wdata;
            if (wr_ok && cfg_addr[3] && (cfg_addr[1:0] != 2'd3))
                nonce[cfg_addr[1:0]] <= cfg_wdata;
            if (wr_ctr)
                ctr <= cfg_wdata;
            else if (inc)
                ctr <= ctr + 32'd1;
            wr_reject_q <= cfg_we && !wr_ok;
            ctr_wrap_q  <= inc && !wr_ctr && (ctr == 32'hFFFF_FFFF);
        end
    end

    always_comb begin
        legal = 1'b0;
        word  = '0;
        case (request_type)
            2'd0: begin
                legal = (chunk_index < 5'd8);
                word  = key[chunk_index[2:0]];
            end
            2'd1: begin
                legal = (chunk_index < 5'd3);
                if (legal)
                    word = nonce[chunk_index[1:0]];
            end
            2'd2: begin
                legal = (chunk_index == 5'd0);
                word  = ctr;
            end
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // HOLD swallows the stale request the top-level keeps asserting.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (chunk_request) begin
                state_nxt = RESP;
                accept    = 1'b1;
            end
            RESP:    state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot taken at the accept edge, so a same-edge host write is not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp      <= '0;
            req_err_q <= 1'b0;
        end else begin
            resp.valid <= accept && legal;
            resp.typ   <= (accept && legal) ? request_type : 2'd0;
            resp.data  <= (accept && legal) ? word : 32'd0;
            req_err_q  <= accept && !legal;
        end
    end

    assign chunk_valid = resp.valid;
    assign chunk_type  = resp.typ;
    assign chunk       = resp.data;
    assign req_err     = req_err_q;
    assign wr_reject   = wr_reject_q;
    assign ctr_wrap    = ctr_wrap_q;

endmodule
